// File: rtl/shift_seq.sv
// shift_seq: multi-step sequencer that drives a single-step ALU for x86 shift/rotate group ops.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               request pulse, accepted when not busy (IDLE or DONE)
//   mode, bit16         shift op (0 ROL,1 ROR,2 RCL,3 RCR,4/6 SHL,5 SHR,7 SAR) and operand width
//   op_in, count        operand and raw count (masked by CNT_MASK)
//   flags_in            incoming flags (CF0 PF2 AF4 ZF6 SF7 OF11)
//   alu_code/op1/bit16/flags -> ALU, alu_result <- ALU one-step result
//   busy, done          busy in RUN, done pulses one cycle with result/flags_out valid
//   result, flags_out   final value (upper byte zero in 8-bit mode) and flags
module shift_seq #(
    parameter logic [4:0] CNT_MASK = 5'h1F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic        bit16,
    input  logic [15:0] op_in,
    input  logic [7:0]  count,
    input  logic [11:0] flags_in,
    output logic [3:0]  alu_code,
    output logic [15:0] alu_op1,
    output logic        alu_bit16,
    output logic [11:0] alu_flags,
    input  logic [15:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [11:0] flags_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic        bit16_q, bit16_d;
    logic [11:0] flags_q, flags_d;
    logic        cf_q, cf_d;
    logic [15:0] reg_q, reg_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        omsb_q, omsb_d;
    logic [15:0] result_q, result_d;
    logic [11:0] fout_q, fout_d;
    logic [7:0]  n;
    logic [15:0] in_masked, r_next;
    logic        accept, left, out_bit, msb, msb1, of;
    logic [11:0] fin;
    always_comb begin
        n         = count & {3'b000, CNT_MASK};
        accept    = start && state_q != RUN;
        in_masked = bit16 ? op_in : {8'h00, op_in[7:0]};
        r_next    = bit16_q ? alu_result : {8'h00, alu_result[7:0]};
        // Even modes (ROL/RCL/SHL) move bits toward the msb.
        left      = ~mode_q[0];
        out_bit   = left ? (bit16_q ? reg_q[15] : reg_q[7]) : reg_q[0];
        msb       = bit16_q ? r_next[15] : r_next[7];
        msb1      = bit16_q ? r_next[14] : r_next[6];
        of        = left ? msb ^ out_bit : mode_q == 3'd5 ? omsb_q : mode_q == 3'd7 ? 1'b0 : msb ^ msb1;
        fin       = flags_q;
        fin[0]    = out_bit;
        fin[11]   = of;
        // Only the true shifts (mode[2]) update ZF/SF/PF.
        fin[6]    = mode_q[2] ? ~|r_next : flags_q[6];
        fin[7]    = mode_q[2] ? msb : flags_q[7];
        fin[2]    = mode_q[2] ? ~^r_next[7:0] : flags_q[2];
        state_d   = state_q;
        mode_d    = mode_q;
        bit16_d   = bit16_q;
        flags_d   = flags_q;
        cf_d      = cf_q;
        reg_d     = reg_q;
        cnt_d     = cnt_q;
        omsb_d    = omsb_q;
        result_d  = result_q;
        fout_d    = fout_q;
        if (accept) begin
            mode_d  = mode;
            bit16_d = bit16;
            flags_d = flags_in;
            cf_d    = flags_in[0];
            reg_d   = in_masked;
            cnt_d   = n;
            omsb_d  = bit16 ? op_in[15] : op_in[7];
            state_d = n == 8'd0 ? DONE : RUN;
            if (n == 8'd0) begin
                result_d = in_masked;
                fout_d   = flags_in;
            end
        end else if (state_q == RUN) begin
            reg_d = r_next;
            cnt_d = cnt_q - 8'd1;
            cf_d  = out_bit;
            if (cnt_q == 8'd1) begin
                state_d  = DONE;
                result_d = r_next;
                fout_d   = fin;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= 3'd0;
            bit16_q  <= 1'b0;
            flags_q  <= 12'h000;
            cf_q     <= 1'b0;
            reg_q    <= 16'h0000;
            cnt_q    <= 8'd0;
            omsb_q   <= 1'b0;
            result_q <= 16'h0000;
            fout_q   <= 12'h000;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            bit16_q  <= bit16_d;
            flags_q  <= flags_d;
            cf_q     <= cf_d;
            reg_q    <= reg_d;
            cnt_q    <= cnt_d;
            omsb_q   <= omsb_d;
            result_q <= result_d;
            fout_q   <= fout_d;
        end
    end
    assign alu_code  = {1'b1, mode_q};
    assign alu_op1   = reg_q;
    assign alu_bit16 = bit16_q;
    assign alu_flags = {flags_q[11:1], cf_q};
    assign busy      = state_q == RUN;
    assign done      = state_q == DONE;
    assign result    = result_q;
    assign flags_out = fout_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed table-driven bench for shift_seq with a behavioural one-step ALU.
module tb_shift_seq;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, bit16 = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [15:0] op_in = 16'h0;
    logic [7:0]  count = 8'h0;
    logic [11:0] flags_in = 12'h0;
    logic [3:0]  alu_code;
    logic [15:0] alu_op1, alu_result, result;
    logic        alu_bit16, busy, done;
    logic [11:0] alu_flags, flags_out;
    int checks = 0, failures = 0;

    typedef struct {
        logic [2:0]  mode;
        logic        b16;
        logic [15:0] op;
        logic [7:0]  cnt;
        logic [11:0] fl;
        logic [15:0] res;
        logic [11:0] fo;
        int          lat;
    } vec_t;
    vec_t v[13];

    shift_seq dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .bit16(bit16),
        .op_in(op_in), .count(count), .flags_in(flags_in), .alu_code(alu_code),
        .alu_op1(alu_op1), .alu_bit16(alu_bit16), .alu_flags(alu_flags),
        .alu_result(alu_result), .busy(busy), .done(done), .result(result),
        .flags_out(flags_out)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] alu_model(input logic [3:0] code, input logic [15:0] x,
                                              input logic b16, input logic c);
        logic m;
        m = b16 ? x[15] : x[7];
        case (code)
            4'h8:        return b16 ? {x[14:0], x[15]} : {8'h00, x[6:0], x[7]};
            4'h9:        return b16 ? {x[0], x[15:1]}  : {8'h00, x[0], x[7:1]};
            4'hA:        return b16 ? {x[14:0], c}     : {8'h00, x[6:0], c};
            4'hB:        return b16 ? {c, x[15:1]}     : {8'h00, c, x[7:1]};
            4'hC, 4'hE:  return b16 ? {x[14:0], 1'b0}  : {8'h00, x[6:0], 1'b0};
            4'hD:        return b16 ? {1'b0, x[15:1]}  : {8'h00, 1'b0, x[7:1]};
            4'hF:        return b16 ? {m, x[15:1]}     : {8'h00, m, x[7:1]};
            default:     return 16'hDEAD;
        endcase
    endfunction

    assign alu_result = alu_model(alu_code, alu_op1, alu_bit16, alu_flags[0]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Starts an op at the current point (may be a DONE cycle) and returns the cycle done was seen.
    task automatic run_op(input vec_t t, output int lat);
        mode = t.mode; bit16 = t.b16; op_in = t.op; count = t.cnt; flags_in = t.fl;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 64; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    int lat;
    logic exp_cf[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        v[0]  = '{3'd4, 1'b0, 16'h0081, 8'd3,    12'h000, 16'h0008, 12'h000, 4};
        v[1]  = '{3'd1, 1'b1, 16'h0001, 8'd1,    12'h0C4, 16'h8000, 12'h8C5, 2};
        v[2]  = '{3'd2, 1'b0, 16'h0080, 8'd9,    12'h000, 16'h0080, 12'h800, 10};
        v[3]  = '{3'd7, 1'b0, 16'h0080, 8'h21,   12'h000, 16'h00C0, 12'h084, 2};
        v[4]  = '{3'd4, 1'b1, 16'h1234, 8'd0,    12'h8C5, 16'h1234, 12'h8C5, 1};
        v[5]  = '{3'd5, 1'b0, 16'h1234, 8'd2,    12'h010, 16'h000D, 12'h010, 3};
        v[6]  = '{3'd0, 1'b1, 16'h8001, 8'd4,    12'h0C4, 16'h0018, 12'h0C4, 5};
        v[7]  = '{3'd3, 1'b0, 16'h0001, 8'd2,    12'h001, 16'h00C0, 12'h000, 3};
        v[8]  = '{3'd6, 1'b1, 16'h4000, 8'd1,    12'h000, 16'h8000, 12'h884, 2};
        v[9]  = '{3'd5, 1'b1, 16'h8000, 8'd16,   12'h000, 16'h0000, 12'h845, 17};
        v[10] = '{3'd7, 1'b1, 16'h8000, 8'hFF,   12'h000, 16'hFFFF, 12'h085, 32};
        v[11] = '{3'd4, 1'b0, 16'hFF80, 8'd1,    12'h000, 16'h0000, 12'h845, 2};
        v[12] = '{3'd1, 1'b0, 16'hABCD, 8'h20,   12'h123, 16'h00CD, 12'h123, 1};

        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_flags", {20'b0, flags_out}, 32'd0);
        chk("rst_alu_code", {28'b0, alu_code}, 32'h8);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Each vector starts in the DONE cycle of the previous one (back-to-back).
        for (int i = 0; i < 13; i++) begin
            run_op(v[i], lat);
            chk($sformatf("lat_%0d", i), lat, v[i].lat);
            chk($sformatf("res_%0d", i), {16'b0, result}, {16'b0, v[i].res});
            chk($sformatf("flg_%0d", i), {20'b0, flags_out}, {20'b0, v[i].fo});
        end

        // done lasts one cycle; result is held afterwards.
        @(posedge clock); #1;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("idle_not_busy", {31'b0, busy}, 32'd0);
        chk("result_held", {16'b0, result}, 32'h00CD);
        chk("flags_held", {20'b0, flags_out}, 32'h123);

        // RCL 9-step: carry fed to the ALU follows the rotation.
        mode = 3'd2; bit16 = 1'b0; op_in = 16'h0080; count = 8'd9; flags_in = 12'h000;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("rcl_cf_%0d", k + 1), {31'b0, alu_flags[0]}, {31'b0, exp_cf[k]});
            chk($sformatf("rcl_busy_%0d", k + 1), {31'b0, busy}, 32'd1);
            @(posedge clock); #1;
        end
        chk("rcl_done", {31'b0, done}, 32'd1);
        chk("rcl_res", {16'b0, result}, 32'h0080);

        // Long SHR: restart ignored while busy, then reset aborts.
        @(posedge clock); #1;
        mode = 3'd5; bit16 = 1'b1; op_in = 16'hF0F0; count = 8'd20; flags_in = 12'h000;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        mode = 3'd0; count = 8'd0; op_in = 16'h1111; flags_in = 12'hFFF;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("ign_busy", {31'b0, busy}, 32'd1);
        chk("ign_done", {31'b0, done}, 32'd0);
        chk("ign_code", {28'b0, alu_code}, 32'hD);
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", {16'b0, result}, 32'd0);
        chk("abort_flags", {20'b0, flags_out}, 32'd0);
        chk("abort_op1", {16'b0, alu_op1}, 32'd0);
        chk("abort_code", {28'b0, alu_code}, 32'h8);
        chk("abort_aflags", {20'b0, alu_flags}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (25) begin
                @(posedge clock); #1;
                if (done || busy) seen++;
            end
            chk("abort_no_done", seen, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
